// File: rtl/matrix_out_stream.sv
// Streams a captured result vector from the matrix multiply unit one element per
// accepted handshake, with a sticky flag for start pulses that could not be taken.
module matrix_out_stream #(
    parameter int DATA_SIZE   = 8,
    parameter int COLUMN_SIZE = 256
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [DATA_SIZE*COLUMN_SIZE-1:0] datsIn,
    output logic [DATA_SIZE-1:0]             outData,
    output logic                             outValid,
    input  logic                             outReady,
    output logic                             outLast,
    output logic                             busy,
    output logic                             dropErr,
    input  logic                             clearErr,
    output logic [15:0]                      vecCount
);

    localparam int IDX_W = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam int VEC_W = DATA_SIZE * COLUMN_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLUMN_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   index_r, index_s;
    logic [VEC_W-1:0]   shadow_r, shadow_s;
    logic [15:0]        vec_count_r, vec_count_s;
    logic               valid_r, valid_s;
    logic               last_r, last_s;
    logic               busy_r, busy_s;
    logic               drop_err_r, drop_err_s;
    logic               drop_s;
    logic               transfer_s;

    // Next-state, datapath and flag logic; all outputs are re-registered below.
    always_comb begin
        state_s     = state_r;
        index_s     = index_r;
        shadow_s    = shadow_r;
        vec_count_s = vec_count_r;
        drop_s      = 1'b0;
        transfer_s  = valid_r & outReady;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                state_s  = ST_STREAM;
                shadow_s = datsIn;
                index_s  = {IDX_W{1'b0}};
                drop_s   = start;
            end
            ST_STREAM: begin
                if (transfer_s) begin
                    // The shadow shifts down so the current element is always in the low slot.
                    shadow_s = shadow_r >> DATA_SIZE;
                    if (last_r) begin
                        vec_count_s = vec_count_r + 16'd1;
                        index_s     = {IDX_W{1'b0}};
                        if (start) begin
                            state_s = ST_WAIT;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        index_s = index_r + IDX_W'(1);
                        drop_s  = start;
                    end
                end else begin
                    drop_s = start;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                index_s  = {IDX_W{1'b0}};
                shadow_s = {VEC_W{1'b0}};
            end
        endcase

        valid_s = (state_s == ST_STREAM);
        last_s  = (state_s == ST_STREAM) && (index_s == LAST_IDX);
        busy_s  = (state_s != ST_IDLE);

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop_s) begin
            drop_err_s = 1'b1;
        end else if (clearErr) begin
            drop_err_s = 1'b0;
        end else begin
            drop_err_s = drop_err_r;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            index_r     <= {IDX_W{1'b0}};
            shadow_r    <= {VEC_W{1'b0}};
            vec_count_r <= 16'd0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            drop_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            index_r     <= index_s;
            shadow_r    <= shadow_s;
            vec_count_r <= vec_count_s;
            valid_r     <= valid_s;
            last_r      <= last_s;
            busy_r      <= busy_s;
            drop_err_r  <= drop_err_s;
        end
    end

    assign outData  = shadow_r[DATA_SIZE-1:0];
    assign outValid = valid_r;
    assign outLast  = last_r;
    assign busy     = busy_r;
    assign dropErr  = drop_err_r;
    assign vecCount = vec_count_r;

endmodule

// File: tb/tb_matrix_out_stream.sv
// Directed self-checking bench for matrix_out_stream with DATA_SIZE=8, COLUMN_SIZE=4.
module tb_matrix_out_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] datsIn;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic        outLast;
    logic        busy;
    logic        dropErr;
    logic        clearErr;
    logic [15:0] vecCount;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_out_stream #(.DATA_SIZE(8), .COLUMN_SIZE(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .datsIn   (datsIn),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outLast  (outLast),
        .busy     (busy),
        .dropErr  (dropErr),
        .clearErr (clearErr),
        .vecCount (vecCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic elem(input string tag, input logic [7:0] d, input logic l);
        check({tag, "_valid"}, 32'(outValid), 32'd1);
        check({tag, "_data"}, 32'(outData), 32'(d));
        check({tag, "_last"}, 32'(outLast), 32'(l));
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_data"}, 32'(outData), 32'd0);
        check({tag, "_valid"}, 32'(outValid), 32'd0);
        check({tag, "_last"}, 32'(outLast), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drop"}, 32'(dropErr), 32'd0);
        check({tag, "_count"}, 32'(vecCount), 32'd0);
    endtask

    // Full vector from IDLE with outReady held high; expected elements come from vec.
    task automatic run_vec(input string tag, input logic [31:0] vec, input logic [15:0] exp_cnt);
        logic [7:0] d;
        datsIn = vec;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_wait_busy"}, 32'(busy), 32'd1);
        check({tag, "_wait_valid"}, 32'(outValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            d = vec[i*8 +: 8];
            elem($sformatf("%s_e%0d", tag, i), d, (i == 3));
        end
        tick();
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_valid"}, 32'(outValid), 32'd0);
        check({tag, "_end_count"}, 32'(vecCount), 32'(exp_cnt));
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        datsIn   = 32'h0;
        outReady = 1'b1;
        clearErr = 1'b0;
        #3;
        all_zero("reset");
        tick();
        reset = 1'b1;
        tick();

        // Basic stream
        datsIn = 32'h44332211;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("t1_wait_busy", 32'(busy), 32'd1);
        check("t1_wait_valid", 32'(outValid), 32'd0);
        tick(); elem("t1_e0", 8'h11, 1'b0);
        tick(); elem("t1_e1", 8'h22, 1'b0);
        tick(); elem("t1_e2", 8'h33, 1'b0);
        tick(); elem("t1_e3", 8'h44, 1'b1);
        tick();
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_valid", 32'(outValid), 32'd0);
        check("t1_count", 32'(vecCount), 32'd1);

        // Backpressure on element 22
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); elem("t2_e0", 8'h11, 1'b0);
        tick(); elem("t2_e1", 8'h22, 1'b0);
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); elem($sformatf("t2_hold%0d", i), 8'h22, 1'b0);
        end
        outReady = 1'b1;
        tick(); elem("t2_e2", 8'h33, 1'b0);
        tick(); elem("t2_e3", 8'h44, 1'b1);
        tick();
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_count", 32'(vecCount), 32'd2);

        // Dropped start during STREAM, clear, and clear colliding with a drop in WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); elem("t3_e0", 8'h11, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_drop_set", 32'(dropErr), 32'd1);
        elem("t3_e1", 8'h22, 1'b0);
        tick(); elem("t3_e2", 8'h33, 1'b0);
        tick(); elem("t3_e3", 8'h44, 1'b1);
        tick();
        check("t3_count", 32'(vecCount), 32'd3);
        check("t3_drop_sticky", 32'(dropErr), 32'd1);
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        check("t3_drop_clear", 32'(dropErr), 32'd0);
        start = 1'b1;
        tick();
        clearErr = 1'b1;
        tick();
        start    = 1'b0;
        clearErr = 1'b0;
        check("t3_set_wins", 32'(dropErr), 32'd1);
        elem("t3b_e0", 8'h11, 1'b0);
        tick(); elem("t3b_e1", 8'h22, 1'b0);
        tick(); elem("t3b_e2", 8'h33, 1'b0);
        tick(); elem("t3b_e3", 8'h44, 1'b1);
        tick();
        check("t3b_count", 32'(vecCount), 32'd4);
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        check("t3b_drop_clear", 32'(dropErr), 32'd0);

        // Start coincident with the last transfer; datsIn changes after capture
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); elem("t4_e0", 8'h11, 1'b0);
        tick(); elem("t4_e1", 8'h22, 1'b0);
        tick(); elem("t4_e2", 8'h33, 1'b0);
        tick(); elem("t4_e3", 8'h44, 1'b1);
        start  = 1'b1;
        datsIn = 32'hDDCCBBAA;
        tick();
        start = 1'b0;
        check("t4_wait_valid", 32'(outValid), 32'd0);
        check("t4_wait_busy", 32'(busy), 32'd1);
        check("t4_wait_count", 32'(vecCount), 32'd5);
        check("t4_wait_drop", 32'(dropErr), 32'd0);
        tick(); elem("t4_f0", 8'hAA, 1'b0);
        datsIn = 32'h0;
        tick(); elem("t4_f1", 8'hBB, 1'b0);
        tick(); elem("t4_f2", 8'hCC, 1'b0);
        tick(); elem("t4_f3", 8'hDD, 1'b1);
        tick();
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_count", 32'(vecCount), 32'd6);
        check("t4_drop", 32'(dropErr), 32'd0);

        // Asynchronous reset mid-stream
        datsIn = 32'h44332211;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick(); elem("t5_e0", 8'h11, 1'b0);
        tick(); elem("t5_e1", 8'h22, 1'b0);
        tick(); elem("t5_e2", 8'h33, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        all_zero("t5_async");
        tick();
        reset = 1'b1;
        tick();
        run_vec("t5_after", 32'h88776655, 16'd1);

        // Counter wrap: preload to 0xFFFE, then complete two vectors
        force dut.vec_count_r = 16'hFFFE;
        #1;
        release dut.vec_count_r;
        #1;
        run_vec("t6_ffff", 32'h0403A0B0, 16'hFFFF);
        run_vec("t6_wrap", 32'hF1E2D3C4, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
